// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared definitions for the multiplexed 7-segment scan controller.
//   HEX_SEG  : hex nibble -> {g,f,e,d,c,b,a} segment pattern, active-low
//   SEG_OFF  : all segments (including dp) off on the active-low bus
//   scan_state_e : scan FSM encoding
package seg_pkg;

  // Active-low segment bus value with every segment and the dp dark.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Standard hex glyphs, bit order gfedcba, 0 = segment lit.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

  // OFF   : display dark, counters parked at zero
  // BLANK : first part of a digit slot, all selects off (anti-ghosting gap)
  // SHOW  : remainder of the slot, current digit driven
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// seg_hex_decode: combinational hex nibble to 7-segment decoder.
//   nibble : 4-bit hex value
//   seg    : {g,f,e,d,c,b,a}, active-low
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scan controller.
//
// Time-shares the segment bus over DIGITS digit selects. Every digit slot is
// DIV = CLK_FREQ/SCAN_HZ cycles long: BLANK_CYC all-off cycles followed by
// DIV-BLANK_CYC lit cycles. Display data, decimal points and the leading-zero
// suppression mask are captured into shadow registers once per frame so a
// frame never mixes old and new digits.
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   en         : scan enable, 0 = display dark
//   lz_en      : leading-zero suppression enable (captured per frame)
//   disp_data  : hex nibbles, nibble i drives digit i (DIGITS-1 = MSD)
//   disp_dp    : decimal point per digit, 1 = lit
//   seg_sel    : digit select, active-low, one-hot-low while a digit is lit
//   seg_led    : {dp,g,f,e,d,c,b,a}, active-low
//   frame_done : one-cycle pulse when the scan wraps from the last digit to 0
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int DIGITS    = 6,
  parameter int BLANK_CYC = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                lz_en,
  input  logic [4*DIGITS-1:0] disp_data,
  input  logic [DIGITS-1:0]   disp_dp,
  output logic [DIGITS-1:0]   seg_sel,
  output logic [7:0]          seg_led,
  output logic                frame_done
);

  localparam int DIV   = CLK_FREQ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // Elaboration-time parameter sanity.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be in 1..8");
  end
  if (BLANK_CYC < 1 || BLANK_CYC >= DIV - 1) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYC must be in 1..DIV-2");
  end

  // --------------------------------------------------------------------------
  // Scan state
  // --------------------------------------------------------------------------
  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                snap;  // capture inputs into the shadow registers
  logic                wrap;  // last digit finishing, frame boundary

  // Shadow copy of the display inputs for the frame being shown.
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   supp_sh;
  logic [DIGITS-1:0]   supp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. Dropping en overrides everything, including a frame
  // wrap in the same cycle, so no frame_done or snapshot happens then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    wrap    = 1'b0;
    if (!en) begin
      state_d = OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          snap    = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
              snap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero mask, evaluated on the live inputs and captured with them.
  // Walking down from the MSD, a digit is suppressed while every nibble from
  // the top down to and including it is zero. Digit 0 always shows.
  // --------------------------------------------------------------------------
  logic zero_above;

  always_comb begin
    supp_d     = '0;
    zero_above = lz_en;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (disp_data[4*i +: 4] == 4'h0);
      supp_d[i]  = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh <= '0;
      dp_sh   <= '0;
      supp_sh <= '0;
    end else if (snap) begin
      data_sh <= disp_data;
      dp_sh   <= disp_dp;
      supp_sh <= supp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output path: mux the current shadow nibble, decode, then register.
  // --------------------------------------------------------------------------
  logic [3:0]        cur_nib;
  logic [6:0]        cur_seg;
  logic [DIGITS-1:0] sel_onehot;
  logic              lit;

  assign cur_nib    = data_sh[{idx_q, 2'b00} +: 4];
  assign sel_onehot = DIGITS'(1) << idx_q;
  // en is folded in so the outputs go dark on the same edge the FSM parks.
  assign lit        = en && (state_q == SHOW) && !supp_sh[idx_q];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel    <= '1;
      seg_led    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (lit) begin
        seg_sel <= ~sel_onehot;
        seg_led <= {~dp_sh[idx_q], cur_seg};
      end else begin
        seg_sel <= '1;
        seg_led <= SEG_OFF;
      end
    end
  end

endmodule
